// File: rtl/demux_1a8_seq.sv
// Registered 1-to-8 demultiplexer/deserializer: addressed lane writes or sequential
// 8-beat frame fill with valid/ack hand-off. Optional macro DEMUX_CLR_ON_ACK_EN clears lanes on ack.
module demux_1a8_seq #(
    parameter int DW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] DIN,
    input  logic [2:0]    SEL,
    input  logic          WE,
    input  logic          SER_EN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [DW-1:0] Q0,
    output logic [DW-1:0] Q1,
    output logic [DW-1:0] Q2,
    output logic [DW-1:0] Q3,
    output logic [DW-1:0] Q4,
    output logic [DW-1:0] Q5,
    output logic [DW-1:0] Q6,
    output logic [DW-1:0] Q7,
    output logic [2:0]    CNT,
    output logic          OUT_VALID,
    input  logic          OUT_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_n;
    logic [2:0]    cnt_r;
    logic [2:0]    cnt_n;
    logic          ov_r;
    logic          ov_n;
    logic [DW-1:0] q_r [8];
    logic          wr_en_s;
    logic [2:0]    wr_idx_s;
    logic          clr_s;

    // Next-state, lane-write selection and frame bookkeeping
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        ov_n     = ov_r;
        wr_en_s  = 1'b0;
        wr_idx_s = 3'd0;
        clr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // A frame start wins over a simultaneous addressed write
                if (SER_EN && IN_VALID) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = 3'd0;
                    cnt_n    = 3'd1;
                    state_n  = FILL;
                end else if (WE) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = SEL;
                end else begin
                    state_n  = IDLE;
                end
            end
            FILL: begin
                if (IN_VALID) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = cnt_r;
                    cnt_n    = cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        ov_n    = 1'b1;
                        state_n = HOLD;
                    end else begin
                        state_n = FILL;
                    end
                end else begin
                    state_n = FILL;
                end
            end
            HOLD: begin
                if (OUT_ACK) begin
                    ov_n    = 1'b0;
                    state_n = IDLE;
`ifdef DEMUX_CLR_ON_ACK_EN
                    clr_s   = 1'b1;
`else
                    clr_s   = 1'b0;
`endif
                end else begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 3'd0;
                ov_n    = 1'b0;
            end
        endcase
    end

    // State, pointer, valid flag and lane registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            ov_r    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                q_r[i] <= {DW{1'b0}};
            end
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ov_r    <= ov_n;
            for (int i = 0; i < 8; i++) begin
                if (clr_s) begin
                    q_r[i] <= {DW{1'b0}};
                end else if (wr_en_s && (wr_idx_s == 3'(i))) begin
                    q_r[i] <= DIN;
                end else begin
                    q_r[i] <= q_r[i];
                end
            end
        end
    end

    assign IN_READY  = ~RST & (state_r != HOLD);
    assign CNT       = cnt_r;
    assign OUT_VALID = ov_r;
    assign Q0        = q_r[0];
    assign Q1        = q_r[1];
    assign Q2        = q_r[2];
    assign Q3        = q_r[3];
    assign Q4        = q_r[4];
    assign Q5        = q_r[5];
    assign Q6        = q_r[6];
    assign Q7        = q_r[7];

endmodule

// File: doc/demux_1a8_seq.md
Name: demux_1a8_seq

Overview:
Registered 1-to-8 demultiplexer/deserializer, the receive-side counterpart of the 8-to-1 operand-bit multiplexers in the ALU datapath. It takes one DW-bit lane per accepted beat and steers it into one of eight registered outputs Q0..Q7. Two modes are supported. In addressed mode, SEL selects the lane. In sequence mode, an internal pointer fills lanes 0..7 in order and presents the completed frame through a valid/ack handshake.

Parameters:
DW, 1, width of each data lane (DIN and Q0..Q7); legal values 1..32

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
DIN  input  DW  data lane to be steered
SEL  input  3  target lane for an addressed write
WE  input  1  addressed-write strobe; honoured only in IDLE
SER_EN  input  1  selects sequence mode; sampled only in IDLE
IN_VALID  input  1  sequence-mode beat valid
IN_READY  output  1  sequence-mode beat accepted when IN_VALID & IN_READY
Q0..Q7  output  DW each  registered lane outputs
CNT  output  3  sequence pointer, i.e. the next lane to be filled
OUT_VALID  output  1  frame complete; held until acknowledged
OUT_ACK  input  1  frame consumed

Behaviour:
Reset:
- Edge with RST=1: state=IDLE, Q0..Q7=0, CNT=0, OUT_VALID=0.
- RST has priority over every other input.
- IN_READY is combinational: IN_READY = ~RST & (state != HOLD).

IDLE:
- If SER_EN & IN_VALID: Q0<=DIN, CNT<=1, go to FILL. Any WE in the same cycle is dropped.
- Else if WE: Q[SEL]<=DIN, stay in IDLE, CNT unchanged.
- Else: hold all state.

FILL:
- On IN_VALID: Q[CNT]<=DIN, CNT<=CNT+1.
- When a beat is accepted with CNT==7: CNT wraps to 0, OUT_VALID<=1, go to HOLD.
- WE is ignored.
- SER_EN is ignored, so the frame always completes.
- Cycles with IN_VALID=0 leave all state unchanged; gaps between beats are allowed.

HOLD:
- IN_READY=0. IN_VALID, WE and SER_EN are ignored. Q0..Q7 are stable.
- On OUT_ACK: OUT_VALID<=0, go to IDLE.
- A new frame can start in the cycle after the ack edge, at the earliest.

Latency:
- A lane write is visible on Q at the edge that accepts it.
- OUT_VALID rises on the same edge that writes Q7.
- Best-case frame is 8 cycles, plus 1 ack cycle before IDLE is re-entered.

Other rules:
- OUT_ACK outside HOLD is ignored.
- Lanes not written keep their old values. An addressed write does not clear the other lanes.
- Reset mid-FILL or in HOLD aborts the frame. All outputs take their reset values on that edge, and no OUT_VALID is produced.

Optional Feature:
Macro DEMUX_CLR_ON_ACK_EN.
- Defined: on the edge that accepts OUT_ACK in HOLD, Q0..Q7 are cleared to 0 together with OUT_VALID going to 0 and the return to IDLE.
- Not defined: Q0..Q7 retain the frame after the ack until they are overwritten or reset.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset: RST=1 for 2 cycles with random inputs -> Q0..Q7=0, CNT=0, OUT_VALID=0, IN_READY=0 while RST=1, and 1 after release.
2. Addressed writes, DW=4, IDLE: WE with SEL=3, DIN=0xA, then SEL=6, DIN=0x5 -> Q3=0xA, Q6=0x5, all other lanes 0, CNT=0, OUT_VALID=0.
3. Back-to-back frame: SER_EN=1, IN_VALID=1 for 8 cycles with DIN=1..8 -> Q0..Q7=1..8, OUT_VALID=1 on the edge writing Q7, CNT=0, IN_READY=0. Hold OUT_ACK low for 3 cycles -> state unchanged. OUT_ACK=1 -> OUT_VALID=0 and IDLE on the next edge.
4. Gapped frame plus ignored inputs: IN_VALID toggled 1/0 over 16 cycles with WE=1, SEL=0 and SER_EN dropped to 0 mid-frame -> the frame completes after 8 accepted beats, and Q0 holds the first beat value, not the WE data.
5. Priority in IDLE: WE=1, SEL=5, DIN=0xF together with SER_EN=1, IN_VALID=1, DIN=0xF -> Q0=0xF, Q5 unchanged, state=FILL, CNT=1.
6. Reset mid-frame: RST=1 after 4 beats -> Q=0, CNT=0, no OUT_VALID. Rerun scenario 3 under DEMUX_CLR_ON_ACK_EN -> Q0..Q7=0 after the ack edge; without the macro -> Q0..Q7 still 1..8.
